// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word and sends it one bit
// per bit_en strobe, framed by frame_out, with a one-cycle done pulse after the last bit.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_par,
  output logic             data_ready,
  input  logic             bit_en,
  output logic             serial_out,
  output logic             frame_out,
  output logic             done,
  output logic             state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             advance;
  logic             last;

  // Handshake: a word transfers on a rising edge where data_valid and data_ready are
  // both 1; data_ready depends on state only, so upstream may hold data_valid freely.
  assign accept    = (state == IDLE) && data_valid;
  assign advance   = (state == SHIFT) && bit_en;
  assign last      = (count == CW'(WIDTH - 1));
  assign state_dbg = state;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    data_ready = 1'b0;
    case (state)
      IDLE: begin
        data_ready = 1'b1;
        if (data_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (bit_en && last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // serial_out always mirrors the output end of the register as it will be after the
  // edge, so the line is registered and the first bit appears one cycle after accept.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      shreg      <= '0;
      count      <= '0;
      serial_out <= 1'b0;
      frame_out  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shreg      <= data_par;
        count      <= '0;
        serial_out <= MSB_FIRST ? data_par[WIDTH-1] : data_par[0];
        frame_out  <= 1'b1;
      end else if (advance) begin
        if (last) begin
          count      <= '0;
          serial_out <= 1'b0;
          frame_out  <= 1'b0;
          done       <= 1'b1;
        end else begin
          shreg      <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          count      <= count + CW'(1);
          serial_out <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance share one stimulus stream
// and are checked against bit-index expectations and a SIPO scoreboard.
module tb_piso_tx;

  localparam int W = 8;

  logic         clock;
  logic         clear;
  logic         data_valid;
  logic [W-1:0] data_par;
  logic         bit_en;
  logic         m_ready, m_serial, m_frame, m_done, m_state;
  logic         l_ready, l_serial, l_frame, l_done, l_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_l_q[$];
  logic         sb_on = 1'b0;
  logic [W-1:0] m_sipo, l_sipo;
  int           m_n = 0;
  int           l_n = 0;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .clear(clear), .data_valid(data_valid), .data_par(data_par),
    .data_ready(m_ready), .bit_en(bit_en), .serial_out(m_serial),
    .frame_out(m_frame), .done(m_done), .state_dbg(m_state)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .clear(clear), .data_valid(data_valid), .data_par(data_par),
    .data_ready(l_ready), .bit_en(bit_en), .serial_out(l_serial),
    .frame_out(l_frame), .done(l_done), .state_dbg(l_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic bit_of(input logic [W-1:0] word, input int i, input bit msb);
    logic [W-1:0] sh;
    sh = msb ? (word >> (W - 1 - i)) : (word >> i);
    return sh[0];
  endfunction

  // expected output bundle {serial, frame, done, ready} for each instance
  function automatic logic [7:0] exp_bit(input logic [W-1:0] word, input int i);
    return {bit_of(word, i, 1'b1), 3'b100, bit_of(word, i, 1'b0), 3'b100};
  endfunction

  localparam logic [7:0] EXP_DONE = 8'b0011_0011;
  localparam logic [7:0] EXP_IDLE = 8'b0001_0001;

  function automatic logic [7:0] got_bits();
    return {m_serial, m_frame, m_done, m_ready, l_serial, l_frame, l_done, l_ready};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard: downstream SIPO shifts on edges where bit_en and frame_out are both 1
  always @(negedge clock) begin
    if (sb_on && !clear) begin
      if (m_frame && bit_en) begin
        m_sipo = {m_sipo[W-2:0], m_serial};
        m_n++;
        if (m_n == W) begin
          m_n = 0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sipo_msb: got word %h, required none pending", m_sipo);
          end else if (m_sipo !== exp_q[0]) begin
            failures++;
            $display("FAIL sipo_msb: got %h required %h", m_sipo, exp_q[0]);
            void'(exp_q.pop_front());
          end else void'(exp_q.pop_front());
        end
      end
      if (l_frame && bit_en) begin
        l_sipo = {l_serial, l_sipo[W-1:1]};
        l_n++;
        if (l_n == W) begin
          l_n = 0;
          checks++;
          if (exp_l_q.size() == 0) begin
            failures++;
            $display("FAIL sipo_lsb: got word %h, required none pending", l_sipo);
          end else if (l_sipo !== exp_l_q[0]) begin
            failures++;
            $display("FAIL sipo_lsb: got %h required %h", l_sipo, exp_l_q[0]);
            void'(exp_l_q.pop_front());
          end else void'(exp_l_q.pop_front());
        end
      end
    end
  end

  task automatic test_reset();
    clear = 1'b1; data_valid = 1'b0; data_par = '0; bit_en = 1'b0;
    #1;
    checks++;
    if (got_bits() !== EXP_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %b required %b", got_bits(), EXP_IDLE);
    end
    tick();
    tick();
    clear = 1'b0;
  endtask

  // bit_en tied 1: WIDTH consecutive bits, then done with ready
  task automatic test_single(input logic [W-1:0] word);
    bit_en = 1'b1; data_valid = 1'b1; data_par = word;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      data_par = W'($urandom);
      checks++;
      if (got_bits() !== exp_bit(word, i)) begin
        failures++;
        $display("FAIL single_%h_bit%0d: got %b required %b", word, i, got_bits(), exp_bit(word, i));
      end
      tick();
    end
    checks++;
    if (got_bits() !== EXP_DONE) begin
      failures++;
      $display("FAIL single_%h_done: got %b required %b", word, got_bits(), EXP_DONE);
    end
    tick();
    checks++;
    if (got_bits() !== EXP_IDLE) begin
      failures++;
      $display("FAIL single_%h_after: got %b required %b", word, got_bits(), EXP_IDLE);
    end
  endtask

  // bit_en every 4th cycle: each bit held 4 cycles, 32 frame cycles, one done
  task automatic test_bit_en_gap();
    int frame_cnt;
    int done_cnt;
    logic [7:0] exp;
    frame_cnt = 0; done_cnt = 0;
    bit_en = 1'b1; data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got_bits() !== EXP_IDLE) begin
        failures++;
        $display("FAIL idle_ignores_bit_en: got %b required %b", got_bits(), EXP_IDLE);
      end
    end
    bit_en = 1'b0; data_valid = 1'b1; data_par = 8'hF0;
    tick();
    data_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 32)       exp = exp_bit(8'hF0, c / 4);
      else if (c == 32) exp = EXP_DONE;
      else              exp = EXP_IDLE;
      checks++;
      if (got_bits() !== exp) begin
        failures++;
        $display("FAIL gap_cycle%0d: got %b required %b", c, got_bits(), exp);
      end
      if (m_frame) frame_cnt++;
      if (m_done)  done_cnt++;
      bit_en = (c % 4 == 3);
      data_par = W'($urandom);
      tick();
    end
    checks++;
    if (frame_cnt != 32 || done_cnt != 1) begin
      failures++;
      $display("FAIL gap_totals: got frame=%0d done=%0d required frame=32 done=1", frame_cnt, done_cnt);
    end
  endtask

  // data_valid held: second word taken right after done, one idle cycle between frames
  task automatic test_back_to_back();
    logic [7:0] exp;
    bit_en = 1'b1; data_valid = 1'b1; data_par = 8'h3C;
    tick();
    data_par = 8'hC3;
    for (int s = 0; s < 18; s++) begin
      if (s < 8)       exp = exp_bit(8'h3C, s);
      else if (s == 8) exp = EXP_DONE;
      else if (s < 17) exp = exp_bit(8'hC3, s - 9);
      else             exp = EXP_DONE;
      checks++;
      if (got_bits() !== exp) begin
        failures++;
        $display("FAIL b2b_cycle%0d: got %b required %b", s, got_bits(), exp);
      end
      if (s >= 9) begin
        data_valid = 1'b0;
        data_par = W'($urandom);
      end
      tick();
    end
  endtask

  // clear after the 3rd bit aborts asynchronously; next word starts from its first bit
  task automatic test_clear_mid();
    bit_en = 1'b1; data_valid = 1'b1; data_par = 8'hFF;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_bits() !== exp_bit(8'hFF, i)) begin
        failures++;
        $display("FAIL clear_pre_bit%0d: got %b required %b", i, got_bits(), exp_bit(8'hFF, i));
      end
      if (i < 2) tick();
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (got_bits() !== EXP_IDLE) begin
      failures++;
      $display("FAIL clear_async: got %b required %b", got_bits(), EXP_IDLE);
    end
    #1 clear = 1'b0;
    test_single(8'h81);
  endtask

  // random words and bit_en gaps against a bit-index model plus the SIPO scoreboard
  task automatic test_random(input int n_words);
    logic [W-1:0] w;
    logic [7:0]   exp;
    int           k;
    bit           finished;
    sb_on = 1'b1; m_n = 0; l_n = 0;
    for (int n = 0; n < n_words; n++) begin
      w = W'($urandom);
      data_valid = 1'b1; data_par = w; bit_en = ($urandom_range(0, 1) == 1);
      exp_q.push_back(w);
      exp_l_q.push_back(w);
      tick();
      data_valid = 1'b0;
      k = 0;
      finished = 1'b0;
      for (int c = 0; c < 200 && !finished; c++) begin
        exp = (k < W) ? exp_bit(w, k) : EXP_DONE;
        checks++;
        if (got_bits() !== exp) begin
          failures++;
          $display("FAIL rand_w%0d_c%0d: got %b required %b", n, c, got_bits(), exp);
        end
        if (k == W) finished = 1'b1;
        else begin
          bit_en = ($urandom_range(0, 2) != 0);
          data_par = W'($urandom);
          tick();
          if (bit_en) k++;
        end
      end
      if (!finished) begin
        checks++;
        failures++;
        $display("FAIL rand_timeout_w%0d: got no done within 200 cycles, required done", n);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bit_en = ($urandom_range(0, 1) == 1);
        tick();
        checks++;
        if (got_bits() !== EXP_IDLE) begin
          failures++;
          $display("FAIL rand_idle_w%0d: got %b required %b", n, got_bits(), EXP_IDLE);
        end
      end
    end
    tick();
    sb_on = 1'b0;
    checks++;
    if (exp_q.size() != 0 || exp_l_q.size() != 0) begin
      failures++;
      $display("FAIL sipo_leftover: got %0d/%0d words pending, required 0", exp_q.size(), exp_l_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'h01);
    test_bit_en_gap();
    test_back_to_back();
    test_clear_mid();
    test_random(1000);
    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
